// File: rtl/lsu_mem_if.sv
// lsu_mem_if: MEM-stage load/store initiator for a word-wide data memory.
// Handles one request at a time. Sub-word stores are done as
// read-modify-write. Load data is lane-extracted and extended here.
// The memory itself is only ever accessed a full word at a time.
module lsu_mem_if #(
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_type,
    input  logic [31:0]   req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          dm_wr,
    output logic [2:0]    dm_type,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_din,
    input  logic [31:0]   dm_dout
);

    // Access type codes shared with the pipeline and the data memory.
    localparam logic [2:0] DM_WORD   = 3'd0;
    localparam logic [2:0] DM_HALF   = 3'd1;
    localparam logic [2:0] DM_HALF_U = 3'd2;
    localparam logic [2:0] DM_BYTE   = 3'd3;
    localparam logic [2:0] DM_BYTE_U = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            we_r;
    logic [2:0]      type_r;
    logic [AW+1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic [31:0]     din_r;
    logic [31:0]     rdata_r;
    logic            err_r;
    logic            accept_s;
    logic            req_err_s;

    // Request is rejected for an illegal type, misalignment or an address
    // beyond the memory. Only the error flag matters, so the order of the
    // checks does not change the result.
    function automatic logic req_error(input logic we, input logic [2:0] t,
                                       input logic [31:0] a);
        logic illegal;
        logic misal;
        logic out_of_range;
        case (t)
            DM_WORD, DM_HALF, DM_BYTE: illegal = 1'b0;
            DM_HALF_U, DM_BYTE_U:      illegal = we;
            default:                   illegal = 1'b1;
        endcase
        case (t)
            DM_WORD:            misal = (a[1:0] != 2'b00);
            DM_HALF, DM_HALF_U: misal = a[0];
            default:            misal = 1'b0;
        endcase
        out_of_range = ((a >> (AW + 2)) != 32'd0);
        return illegal | misal | out_of_range;
    endfunction

    // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0] t,
                                                input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (t)
            DM_BYTE:   res = {{24{sh[7]}}, sh[7:0]};
            DM_BYTE_U: res = {24'd0, sh[7:0]};
            DM_HALF:   res = {{16{sh[15]}}, sh[15:0]};
            DM_HALF_U: res = {16'd0, sh[15:0]};
            default:   res = sh;
        endcase
        return res;
    endfunction

    // Replace the addressed lane(s) of the old word with low store data.
    // Halfword offsets are already known to be 0 or 2 here.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0] t,
                                                input logic [1:0] off);
        logic [31:0] m;
        m = word;
        case (t)
            DM_BYTE: m[{off, 3'b000} +: 8]        = wdata[7:0];
            DM_HALF: m[{off[1], 4'b0000} +: 16]   = wdata[15:0];
            default: m                            = wdata;
        endcase
        return m;
    endfunction

    assign accept_s  = req_valid && (state_r == ST_IDLE);
    assign req_err_s = req_error(req_we, req_type, req_addr);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (req_err_s) begin
                    state_nxt_s = ST_RESP;
                end else if (req_we && (req_type == DM_WORD)) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
            ST_RD: begin
                if (we_r) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            ST_WR: begin
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RESP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Request latch, write-word build and response data/error registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_r    <= 1'b0;
            type_r  <= 3'd0;
            addr_r  <= '0;
            wdata_r <= 32'd0;
            din_r   <= 32'd0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        we_r    <= req_we;
                        type_r  <= req_type;
                        addr_r  <= req_addr[AW+1:0];
                        wdata_r <= req_wdata;
                        rdata_r <= 32'd0;
                        err_r   <= req_err_s;
                        if (!req_err_s && req_we && (req_type == DM_WORD)) begin
                            din_r <= req_wdata;
                        end
                    end
                end
                ST_RD: begin
                    if (we_r) begin
                        din_r <= store_merge(dm_dout, wdata_r, type_r, addr_r[1:0]);
                    end else begin
                        rdata_r <= load_extend(dm_dout, type_r, addr_r[1:0]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;
    assign dm_wr     = (state_r == ST_WR);
    assign dm_type   = DM_WORD;
    assign dm_addr   = addr_r[AW+1:2];
    assign dm_din    = din_r;

endmodule
